// File: rtl/sigmoid_alu_divider.sv
// sigmoid_alu_divider: sequential restoring divider, signed dividend by
// unsigned divisor, quotient and remainder truncated toward zero.
// Optional feature macro: SIGMOID_DIV_ZERO_CHECK_EN (saturating divide-by-zero
// fast path with div_zero flag). Without it a zero divisor runs the normal
// iteration and div_zero stays 0.
module sigmoid_alu_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] signval,
  input  logic [DIVISOR_W-1:0]  unsignval,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W:0]    remainder,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  // Magnitude register doubles as the quotient: magnitude bits leave at the
  // MSB while quotient bits enter at the LSB.
  logic [DIVIDEND_W-1:0] mag_q, mag_d;
  logic                  neg_q, neg_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [DIVISOR_W:0]    prem_q, prem_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W:0]    remainder_q, remainder_d;
  logic                  div_zero_q, div_zero_d;

  // One restoring step: shift in the next magnitude bit, trial subtract.
  logic [DIVISOR_W:0]    shifted;
  logic [DIVISOR_W:0]    diff;
  logic                  ge;
  logic                  zero_div;

  always_comb begin
    shifted = {prem_q[DIVISOR_W-1:0], mag_q[DIVIDEND_W-1]};
    ge      = (shifted >= {1'b0, divisor_q});
    diff    = shifted - {1'b0, divisor_q};
  end

  // Zero-divisor detection only exists when the fast path is built in.
  always_comb begin
`ifdef SIGMOID_DIV_ZERO_CHECK_EN
    zero_div = (unsignval == '0);
`else
    zero_div = 1'b0;
`endif
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves it unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = zero_div ? S_DONE : S_CALC;
      end
      S_CALC: begin
        if (cnt_q == CNT_W'(1)) state_d = S_SIGN;
      end
      S_SIGN:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    busy = (state_q == S_CALC) || (state_q == S_SIGN);
    done = (state_q == S_DONE);
  end

  // Datapath next-value logic: operand capture, iteration, sign fix-up.
  always_comb begin
    mag_d       = mag_q;
    neg_d       = neg_q;
    divisor_d   = divisor_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (zero_div) begin
            // Saturate toward the dividend's sign.
            quotient_d  = signval[DIVIDEND_W-1] ? {1'b1, {(DIVIDEND_W-1){1'b0}}}
                                                : {1'b0, {(DIVIDEND_W-1){1'b1}}};
            remainder_d = '0;
            div_zero_d  = 1'b1;
          end else begin
            // -2^(W-1) negates to itself, which reads correctly as unsigned.
            mag_d     = signval[DIVIDEND_W-1] ? -signval : signval;
            neg_d     = signval[DIVIDEND_W-1];
            divisor_d = unsignval;
            prem_d    = '0;
            cnt_d     = CNT_W'(DIVIDEND_W);
          end
        end
      end
      S_CALC: begin
        prem_d = ge ? diff : shifted;
        mag_d  = {mag_q[DIVIDEND_W-2:0], ge};
        cnt_d  = cnt_q - CNT_W'(1);
      end
      S_SIGN: begin
        quotient_d  = neg_q ? -mag_q  : mag_q;
        remainder_d = neg_q ? -prem_q : prem_q;
`ifdef SIGMOID_DIV_ZERO_CHECK_EN
        div_zero_d  = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  // Datapath registers; all cleared by reset, including mid-operation.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mag_q       <= '0;
      neg_q       <= 1'b0;
      divisor_q   <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      mag_q       <= mag_d;
      neg_q       <= neg_d;
      divisor_q   <= divisor_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_sigmoid_alu_divider.sv
// Scoreboard bench for sigmoid_alu_divider: the driver pushes expected results
// computed with plain integer division; a negedge monitor pops on done.
module tb_sigmoid_alu_divider;

  localparam int DW = 8;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [DW-1:0] signval;
  logic [VW-1:0] unsignval;
  logic [DW-1:0] quotient;
  logic [VW:0]   remainder;
  logic          busy;
  logic          done;
  logic          div_zero;

  sigmoid_alu_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .signval   (signval),
    .unsignval (unsignval),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int q;
    int r;
    int dz;
    bit chk_rem;
    int lat;
    int launch;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: SV integer / and % truncate toward zero.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.chk_rem = 1'b1;
    e.launch  = 0;
    if (b == 0) begin
`ifdef SIGMOID_DIV_ZERO_CHECK_EN
      e.q   = (a >= 0) ? (1 << (DW - 1)) - 1 : -(1 << (DW - 1));
      e.r   = 0;
      e.dz  = 1;
      e.lat = 0;
`else
      e.q       = (a >= 0) ? -1 : 1;
      e.r       = 0;
      e.dz      = 0;
      e.chk_rem = 1'b0;
      e.lat     = DW + 1;
`endif
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dz  = 0;
      e.lat = DW + 1;
    end
    return e;
  endfunction

  // Monitor: compare every completion against the oldest expectation.
  always @(negedge clk) begin
    if (n_rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", int'($signed(quotient)), e.q);
        if (e.chk_rem) check("remainder", int'($signed(remainder)), e.r);
        check("div_zero", int'(div_zero), e.dz);
        check("latency", cyc - e.launch - 1, e.lat);
        check("busy_at_done", int'(busy), 0);
      end
    end
  end

  // Launch one operation and wait (bounded) for its done pulse. With poke set,
  // start is re-asserted mid-operation with other operands, which must be ignored.
  task automatic run_op(input int a, input int b, input bit poke);
    exp_t e;
    int   busy_n;
    bit   got;
    @(negedge clk);
    signval   = a[DW-1:0];
    unsignval = b[VW-1:0];
    e         = model(a, b);
    e.launch  = cyc;
    sb.push_back(e);
    start     = 1'b1;
    busy_n    = 0;
    got       = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) busy_n++;
      start = poke && (i == 2);
      if (poke && i == 2) begin
        signval   = DW'($urandom);
        unsignval = VW'($urandom_range(1, (1 << VW) - 1));
      end
    end
    start = 1'b0;
    check("done_seen", int'(got), 1);
    check("busy_cycles", busy_n, e.lat);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst     = 1'b0;
    start     = 1'b0;
    signval   = '0;
    unsignval = '0;
    repeat (2) @(negedge clk);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_div_zero", int'(div_zero), 0);
    n_rst = 1'b1;

    // Directed cases.
    run_op(100, 7, 1'b0);
    run_op(-100, 7, 1'b0);
    run_op(-128, 1, 1'b0);
    run_op(127, 15, 1'b0);
    run_op(0, 5, 1'b0);
    run_op(-5, 0, 1'b0);
    run_op(37, 4, 1'b0);
    run_op(90, 0, 1'b0);
    run_op(-77, 9, 1'b1);
    run_op(127, 15, 1'b0);

    // Reset mid-CALC: outputs must clear asynchronously, no done afterwards.
    @(negedge clk);
    signval   = 8'd100;
    unsignval = 4'd7;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    check("async_rst_quotient", int'(quotient), 0);
    check("async_rst_remainder", int'(remainder), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_div_zero", int'(div_zero), 0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_idle_busy", int'(busy), 0);
    run_op(50, 3, 1'b0);

    // Exhaustive nonzero-divisor sweep, with random mid-operation pokes.
    for (int a = -(1 << (DW - 1)); a < (1 << (DW - 1)); a++) begin
      for (int b = 1; b < (1 << VW); b++) begin
        run_op(a, b, ($urandom_range(0, 15) == 0));
      end
    end

    // Random operands including zero divisors.
    for (int k = 0; k < 200; k++) begin
      int a;
      int b;
      a = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
      b = int'($urandom_range(0, (1 << VW) - 1));
      run_op(a, b, $urandom_range(0, 3) == 0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
